sara_pipe_corr: RTL and testbench

- Next-generation Simple Accuracy-Reconfigurable Adder: parametrised SIZE/GROUPSIZE segmented adder with a valid/ready handshake on both sides.
- Each group boundary carry is either accurate (ripple carry-out of the group) or approximate (generate of the group's top bit), selected per boundary by APPROX_RCON.
- Optional iterative error correction: detects boundaries whose approximate carry is wrong and fixes them one per cycle until the result is exact.
- Sits between operand-issue logic and the accumulate/result stage of the approximate datapath.

---
 rtl/sara_pkg.sv | 12 +
 rtl/sara_pipe_corr_if.sv | 32 +++
 rtl/sara_group_rca.sv | 28 ++
 rtl/sara_pipe_corr.sv | 151 +++++++++++++++
 tb/tb_sara_pipe_corr.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sara_pkg.sv
// Shared types and constants for the SARA segmented adder pipeline.
package sara_pkg;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  localparam int STAT_W = 16;

  function automatic int calc_ngroups(input int size, input int groupsize);
    return (size / groupsize < 1) ? 1 : size / groupsize;
  endfunction

endpackage

// File: rtl/sara_pipe_corr_if.sv
// Operand/result handshake bundle for sara_pipe_corr; master drives operands, slave returns results.
interface sara_pipe_corr_if #(
  parameter int SIZE      = 32,
  parameter int GROUPSIZE = 8
);
  localparam int NGROUPS = sara_pkg::calc_ngroups(SIZE, GROUPSIZE);

  logic               IN_VALID;
  logic               IN_READY;
  logic [SIZE-1:0]    A;
  logic [SIZE-1:0]    B;
  logic               CIN;
  logic [NGROUPS-1:0] APPROX_RCON;
  logic               CORR_EN;
  logic               OUT_VALID;
  logic               OUT_READY;
  logic [SIZE-1:0]    SUM;
  logic               COUT;
  logic               ERR_FLAG;
  logic               CORRECTED;

  modport master (
    output IN_VALID, A, B, CIN, APPROX_RCON, CORR_EN, OUT_READY,
    input  IN_READY, OUT_VALID, SUM, COUT, ERR_FLAG, CORRECTED
  );

  modport slave (
    input  IN_VALID, A, B, CIN, APPROX_RCON, CORR_EN, OUT_READY,
    output IN_READY, OUT_VALID, SUM, COUT, ERR_FLAG, CORRECTED
  );

endinterface

// File: rtl/sara_group_rca.sv
// One GROUPSIZE-bit ripple-carry group: sum, ripple carry-out and generate of its top bit.
module sara_group_rca #(
  parameter int GROUPSIZE = 8
) (
  input  logic [GROUPSIZE-1:0] a,
  input  logic [GROUPSIZE-1:0] b,
  input  logic                 cin,
  output logic [GROUPSIZE-1:0] sum,
  output logic                 cout,
  output logic                 g_top
);

  logic [GROUPSIZE:0] w_c;

  always_comb begin
    w_c    = '0;
    sum    = '0;
    w_c[0] = cin;
    for (int i = 0; i < GROUPSIZE; i++) begin
      sum[i]   = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = w_c[GROUPSIZE];
  assign g_top = a[GROUPSIZE-1] & b[GROUPSIZE-1];

endmodule

// File: rtl/sara_pipe_corr.sv
// Accuracy-reconfigurable segmented adder with valid/ready handshake and iterative carry correction.
// Optional SARA_ERR_STATS_EN adds saturating transaction / error counters.
//
// state | meaning
// IDLE  | waiting for operands, IN_READY=1
// EVAL  | evaluating registered operands; one boundary corrected per cycle
// DONE  | result held on OUT_VALID until downstream accepts it
module sara_pipe_corr
  import sara_pkg::*;
#(
  parameter int SIZE      = 32,
  parameter int GROUPSIZE = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  sara_pipe_corr_if.slave      bus
`ifdef SARA_ERR_STATS_EN
  ,
  output logic [STAT_W-1:0]    TXN_COUNT,
  output logic [STAT_W-1:0]    ERR_COUNT
`endif
);

  localparam int NGROUPS = calc_ngroups(SIZE, GROUPSIZE);

  state_t             r_state;
  logic [SIZE-1:0]    r_a;
  logic [SIZE-1:0]    r_b;
  logic               r_cin;
  logic [NGROUPS-1:0] r_rcon;
  logic [NGROUPS-1:0] r_mask;
  logic               r_corr_en;
  logic               r_first;
  logic               r_out_valid;
  logic [SIZE-1:0]    r_sum;
  logic               r_cout;
  logic               r_err;
  logic               r_corrected;

  logic [NGROUPS:0]   w_carry;
  logic [NGROUPS-1:0] w_ripple;
  logic [NGROUPS-1:0] w_gtop;
  logic [NGROUPS-1:0] w_eff;
  logic [NGROUPS-1:0] w_mis;
  logic [NGROUPS-1:0] w_low_mis;
  logic [SIZE-1:0]    w_sum;
  logic               w_accept;

  assign w_eff      = r_rcon | r_mask;
  assign w_carry[0] = r_cin;

  for (genvar g = 0; g < NGROUPS; g++) begin : g_grp
    sara_group_rca #(.GROUPSIZE(GROUPSIZE)) u_grp (
      .a     (r_a[g*GROUPSIZE +: GROUPSIZE]),
      .b     (r_b[g*GROUPSIZE +: GROUPSIZE]),
      .cin   (w_carry[g]),
      .sum   (w_sum[g*GROUPSIZE +: GROUPSIZE]),
      .cout  (w_ripple[g]),
      .g_top (w_gtop[g])
    );
    assign w_carry[g+1] = w_eff[g] ? w_ripple[g] : w_gtop[g];
    assign w_mis[g]     = !w_eff[g] && (w_gtop[g] != w_ripple[g]);
  end

  // two's-complement trick isolates the lowest mismatching boundary
  assign w_low_mis = w_mis & (-w_mis);

  assign bus.IN_READY  = (r_state == IDLE) || ((r_state == DONE) && bus.OUT_READY);
  assign w_accept      = bus.IN_VALID && bus.IN_READY;
  assign bus.OUT_VALID = r_out_valid;
  assign bus.SUM       = r_sum;
  assign bus.COUT      = r_cout;
  assign bus.ERR_FLAG  = r_err;
  assign bus.CORRECTED = r_corrected;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_mask      <= '0;
      r_first     <= 1'b0;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_err       <= 1'b0;
      r_corrected <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_cin       <= 1'b0;
      r_rcon      <= '0;
      r_corr_en   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) r_state <= EVAL;
        end
        EVAL: begin
          r_first <= 1'b0;
          if (r_first) r_err <= |w_mis;
          if (r_corr_en && (|w_mis)) begin
            r_mask      <= r_mask | w_low_mis;
            r_corrected <= 1'b1;
          end else begin
            r_sum       <= w_sum;
            r_cout      <= w_carry[NGROUPS];
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.OUT_READY) begin
            r_out_valid <= 1'b0;
            r_state     <= bus.IN_VALID ? EVAL : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // accepting overwrites the held flags only once the old result has left
      if (w_accept) begin
        r_a         <= bus.A;
        r_b         <= bus.B;
        r_cin       <= bus.CIN;
        r_rcon      <= bus.APPROX_RCON;
        r_corr_en   <= bus.CORR_EN;
        r_mask      <= '0;
        r_first     <= 1'b1;
        r_err       <= 1'b0;
        r_corrected <= 1'b0;
      end
    end
  end

`ifdef SARA_ERR_STATS_EN
  logic [STAT_W-1:0] r_txn_cnt;
  logic [STAT_W-1:0] r_err_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_txn_cnt <= '0;
      r_err_cnt <= '0;
    end else if (r_out_valid && bus.OUT_READY) begin
      if (r_txn_cnt != '1) r_txn_cnt <= r_txn_cnt + STAT_W'(1);
      if (r_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + STAT_W'(1);
    end
  end

  assign TXN_COUNT = r_txn_cnt;
  assign ERR_COUNT = r_err_cnt;
`endif

endmodule

// File: tb/tb_sara_pipe_corr.sv
// Self-checking bench for sara_pipe_corr: directed cases plus randomized traffic against a reference model.
module tb_sara_pipe_corr;

  localparam int SIZE = 32;
  localparam int GS   = 8;
  localparam int NG   = SIZE / GS;

  typedef struct {
    logic [SIZE-1:0] sum;
    logic            cout;
    logic            err;
    logic            corr;
    int              n;
    int              due;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   started = 1'b0;
  res_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sara_pipe_corr_if #(.SIZE(SIZE), .GROUPSIZE(GS)) bus ();

`ifdef SARA_ERR_STATS_EN
  logic [15:0] txn_count, err_count;
  int m_txn = 0, m_err = 0;
`endif

  sara_pipe_corr #(.SIZE(SIZE), .GROUPSIZE(GS)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
`ifdef SARA_ERR_STATS_EN
    ,
    .TXN_COUNT (txn_count),
    .ERR_COUNT (err_count)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: evaluate group-by-group with integer arithmetic; repeat with the
  // lowest wrong approximate boundary forced accurate until clean or correction is off.
  function automatic res_t model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                 input logic cin, input logic [NG-1:0] rcon, input logic corr_en);
    res_t r;
    logic [NG-1:0] mask;
    mask = '0;
    r.n = 0; r.err = 1'b0; r.sum = '0; r.cout = 1'b0; r.corr = 1'b0; r.due = 0;
    for (int pass = 0; pass <= NG; pass++) begin
      logic [SIZE-1:0] s;
      logic c;
      int low;
      s = '0; c = cin; low = -1;
      for (int gi = 0; gi < NG; gi++) begin
        int unsigned ga, gb, t;
        logic rip, gtop, approx;
        ga = (a >> (gi * GS)) & 32'hFF;
        gb = (b >> (gi * GS)) & 32'hFF;
        t = ga + gb + 32'(c);
        s = s | ((t & 32'hFF) << (gi * GS));
        rip = t[8];
        gtop = ga[7] & gb[7];
        approx = !(rcon[gi] | mask[gi]);
        if (approx && (gtop != rip) && (low < 0)) low = gi;
        c = approx ? gtop : rip;
      end
      if (pass == 0) r.err = (low >= 0);
      if (corr_en && (low >= 0)) begin
        mask[low] = 1'b1;
        r.n++;
      end else begin
        r.sum = s;
        r.cout = c;
        break;
      end
    end
    r.corr = (r.n > 0);
    return r;
  endfunction

  always @(negedge clk) begin : mon
    bit exp_ov, exp_ir;
    res_t r;
    exp_ov = (q.size() > 0) && (cyc >= q[0].due);
    exp_ir = (q.size() == 0) || (exp_ov && bus.OUT_READY);
    if (started) begin
      chk("out_valid", bus.OUT_VALID, exp_ov);
      chk("in_ready", bus.IN_READY, exp_ir);
      if (exp_ov) begin
        chk("sum", bus.SUM, q[0].sum);
        chk("cout", bus.COUT, q[0].cout);
        chk("err_flag", bus.ERR_FLAG, q[0].err);
        chk("corrected", bus.CORRECTED, q[0].corr);
      end
`ifdef SARA_ERR_STATS_EN
      chk("txn_count", txn_count, m_txn);
      chk("err_count", err_count, m_err);
`endif
    end
    if (rst) begin
      q.delete();
      started = 1'b1;
`ifdef SARA_ERR_STATS_EN
      m_txn = 0; m_err = 0;
`endif
    end else if (started) begin
      if (exp_ov && bus.OUT_READY) begin
`ifdef SARA_ERR_STATS_EN
        if (m_txn < 16'hFFFF) m_txn++;
        if (q[0].err && m_err < 16'hFFFF) m_err++;
`endif
        void'(q.pop_front());
      end
      if (bus.IN_VALID && exp_ir) begin
        r = model(bus.A, bus.B, bus.CIN, bus.APPROX_RCON, bus.CORR_EN);
        r.due = cyc + 2 + r.n;
        if (bus.CORR_EN)
          chk("model_exact", 64'({r.cout, r.sum}), 64'(bus.A) + 64'(bus.B) + 64'(bus.CIN));
        q.push_back(r);
      end
    end
  end

  task automatic directed(input string nm, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                          input logic cin, input logic [NG-1:0] rcon, input logic corr_en,
                          input logic [SIZE-1:0] esum, input logic ecout, input logic eerr,
                          input logic ecorr, input int elat);
    int k, t0;
    @(posedge clk); #1;
    bus.IN_VALID = 1'b1; bus.A = a; bus.B = b; bus.CIN = cin;
    bus.APPROX_RCON = rcon; bus.CORR_EN = corr_en; bus.OUT_READY = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.IN_READY && k < 50) begin @(negedge clk); k++; end
    t0 = cyc;
    @(posedge clk); #1 bus.IN_VALID = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.OUT_VALID && k < 50);
    if (!bus.OUT_VALID) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: no OUT_VALID within 50 cycles", nm);
      return;
    end
    chk({nm, "_sum"}, bus.SUM, esum);
    chk({nm, "_cout"}, bus.COUT, ecout);
    chk({nm, "_err"}, bus.ERR_FLAG, eerr);
    chk({nm, "_corr"}, bus.CORRECTED, ecorr);
    chk({nm, "_lat"}, cyc - t0, elat);
  endtask

  function automatic logic [SIZE-1:0] rnd_op();
    logic [SIZE-1:0] v;
    v = $urandom;
    for (int i = 0; i < NG; i++)
      if ($urandom_range(0, 2) == 0) v[i*GS +: GS] = 8'hFF;
    return v;
  endfunction

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    res_t m;
    int k;
    bit seen;
    bus.IN_VALID = 1'b0; bus.A = '0; bus.B = '0; bus.CIN = 1'b0;
    bus.APPROX_RCON = '0; bus.CORR_EN = 1'b0; bus.OUT_READY = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.OUT_VALID, 0);
    chk("rst_in_ready", bus.IN_READY, 1);
    chk("rst_sum", bus.SUM, 0);
    chk("rst_cout", bus.COUT, 0);
    chk("rst_err", bus.ERR_FLAG, 0);
    chk("rst_corr", bus.CORRECTED, 0);

    m = model(32'h000000FF, 32'h1, 1'b0, 4'b0000, 1'b0);
    chk("mdl_approx_sum", m.sum, 32'h0);
    chk("mdl_approx_err", m.err, 1);
    m = model(32'h00FFFFFF, 32'h1, 1'b0, 4'b0000, 1'b1);
    chk("mdl_chain_sum", m.sum, 32'h01000000);
    chk("mdl_chain_n", m.n, 3);
    m = model(32'hFFFFFFFF, 32'h1, 1'b0, 4'b0000, 1'b1);
    chk("mdl_cout_n", m.n, 4);

    directed("t1_accurate",  32'h000000FF, 32'h1, 1'b0, 4'b1111, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0, 2);
    directed("t2_approx",    32'h000000FF, 32'h1, 1'b0, 4'b0000, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 2);
    directed("t3_corr1",     32'h000000FF, 32'h1, 1'b0, 4'b0000, 1'b1, 32'h00000100, 1'b0, 1'b1, 1'b1, 3);
    directed("t4_chain3",    32'h00FFFFFF, 32'h1, 1'b0, 4'b0000, 1'b1, 32'h01000000, 1'b0, 1'b1, 1'b1, 5);
    directed("tc_cout_corr", 32'hFFFFFFFF, 32'h1, 1'b0, 4'b0000, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b1, 6);
    directed("tc_cout_apx",  32'hFFFFFFFF, 32'h1, 1'b0, 4'b0000, 1'b0, 32'hFFFFFF00, 1'b0, 1'b1, 1'b0, 2);

    // backpressure, then output handshake and new accept in the same cycle
    @(posedge clk); #1;
    bus.IN_VALID = 1'b1; bus.A = 32'h00FFFFFF; bus.B = 32'h1; bus.CIN = 1'b0;
    bus.APPROX_RCON = 4'b0000; bus.CORR_EN = 1'b1; bus.OUT_READY = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 bus.IN_VALID = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.OUT_VALID && k < 50);
    chk("t5_valid_seen", bus.OUT_VALID, 1);
    repeat (4) begin
      @(negedge clk);
      chk("t5_hold_sum", bus.SUM, 32'h01000000);
      chk("t5_in_ready", bus.IN_READY, 0);
    end
    @(posedge clk); #1;
    bus.IN_VALID = 1'b1; bus.A = 32'h5; bus.B = 32'h7; bus.APPROX_RCON = 4'b1111;
    bus.CORR_EN = 1'b0; bus.OUT_READY = 1'b1;
    @(negedge clk);
    chk("t5_both_ready", bus.IN_READY, 1);
    chk("t5_both_valid", bus.OUT_VALID, 1);
    @(posedge clk); #1 bus.IN_VALID = 1'b0;
    @(negedge clk);
    chk("t5_nobubble_ir", bus.IN_READY, 0);
    @(negedge clk);
    chk("t5_next_valid", bus.OUT_VALID, 1);
    chk("t5_next_sum", bus.SUM, 32'hC);

    // reset during the second correction cycle drops the transaction
    @(posedge clk); #1;
    bus.IN_VALID = 1'b1; bus.A = 32'h00FFFFFF; bus.B = 32'h1; bus.CIN = 1'b0;
    bus.APPROX_RCON = 4'b0000; bus.CORR_EN = 1'b1; bus.OUT_READY = 1'b1;
    @(negedge clk);
    chk("t6_accept", bus.IN_READY, 1);
    @(posedge clk); #1 bus.IN_VALID = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_out_valid", bus.OUT_VALID, 0);
    chk("t6_in_ready", bus.IN_READY, 1);
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (bus.OUT_VALID) seen = 1'b1; end
    chk("t6_no_output", seen, 0);
    directed("t6_after", 32'h12FF34FF, 32'h00010001, 1'b0, 4'b0101, 1'b1, 32'h13003500, 1'b0, 1'b0, 1'b0, 2);

    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      bus.IN_VALID    = 1'($urandom_range(0, 1));
      bus.A           = rnd_op();
      bus.B           = rnd_op();
      bus.CIN         = 1'($urandom_range(0, 1));
      bus.APPROX_RCON = 4'($urandom);
      bus.CORR_EN     = ($urandom_range(0, 3) != 0);
      bus.OUT_READY   = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
